ex_muldiv: RTL and testbench

EX_MULDIV -- requirements
Module: ex_muldiv

---
 rtl/muldiv_pkg.sv | 30 +++
 rtl/ex_muldiv_div_iter.sv | 56 +++++
 rtl/ex_muldiv.sv | 166 ++++++++++++++++
 tb/tb_ex_muldiv.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings for the EX-stage multiply/divide unit.
// Holds funct3 op codes, FSM state encoding, iteration count and a
// conditional-negate helper used for operand magnitudes and result signs.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // One product/quotient bit per cycle over a 32-bit operand.
  localparam logic [5:0] ITER_N = 6'd32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Two's-complement negate when neg is set, pass-through otherwise.
  function automatic logic [31:0] cneg32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/ex_muldiv_div_iter.sv
// div_iter: restoring divider datapath on unsigned magnitudes.
// Latency: load, then one quotient bit per step; iter_done after 32 steps.
// Backpressure: none; the owning FSM decides when to step.
// Ports: clk, rst (async active-low), load/step controls, dividend/divisor
// magnitudes in, quotient/remainder magnitudes out, iter_done when the
// iteration counter reaches 32 (also used by the FSM to time multiplies).
module div_iter
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        iter_done
);

  logic [5:0]  cnt;
  logic [31:0] dvsr_q;
  logic [32:0] rem_sh;
  logic [32:0] diff;

  // The quotient register starts out holding the dividend; its MSB is
  // shifted into the partial remainder while quotient bits fill from below.
  assign rem_sh    = {remainder, quotient[31]};
  // rem_sh < 2*divisor, so diff fits a 33-bit signed value: bit 32 is borrow.
  assign diff      = rem_sh - {1'b0, dvsr_q};
  assign iter_done = (cnt == ITER_N);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      dvsr_q    <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else if (load) begin
      cnt       <= '0;
      dvsr_q    <= divisor;
      quotient  <= dividend;
      remainder <= '0;
    end else if (step) begin
      cnt <= cnt + 6'd1;
      if (!diff[32]) begin
        remainder <= diff[31:0];
        quotient  <= {quotient[30:0], 1'b1};
      end else begin
        remainder <= rem_sh[31:0];
        quotient  <= {quotient[30:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: RV32M multiply/divide unit for the EX stage.
// Latency: 33 cycles start->done (1 for div-by-zero/overflow, 1 for multiply
// with MULDIV_FAST_MUL_EN defined). Backpressure: stall freezes IF/ID/ID_EX.
// Ports: clk, rst (async active-low); start/Flush/funct3/op_a/op_b/rd_in from
// ID_EX; stall to the front end; done pulse with result and rd_out.
// Optional feature macro: MULDIV_FAST_MUL_EN (single-cycle 64-bit multiplier).
module ex_muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        Flush,
  input  logic [2:0]  funct3,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [4:0]  rd_in,
  output logic        stall,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  rd_out
);
  import muldiv_pkg::*;

  state_t      state;
  logic [2:0]  f3_q;
  logic [4:0]  rd_q;
  logic [31:0] a_q;
  logic [31:0] ma_q;
  logic [63:0] prod_q;
  logic        neg_q;    // product / quotient negation
  logic        rneg_q;   // remainder takes dividend sign
  logic        dz_q;
  logic        ovf_q;

  logic        a_sgn, b_sgn, sa, sb;
  logic [31:0] mag_a, mag_b;
  logic        accept, iter_step, iter_done, is_rem;
  logic [31:0] quo, rem;
  logic [63:0] prod_raw, prod_fix;
  logic        mul_last;
  logic [31:0] mul_res, div_res, spec_res;

  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    case (funct3)
      F3_MUL, F3_MULH, F3_DIV, F3_REM: begin
        a_sgn = 1'b1;
        b_sgn = 1'b1;
      end
      F3_MULHSU:                a_sgn = 1'b1;
      F3_MULHU, F3_DIVU, F3_REMU: ;
      default: ;
    endcase
  end

  assign sa    = a_sgn & op_a[31];
  assign sb    = b_sgn & op_b[31];
  assign mag_a = cneg32(op_a, sa);
  assign mag_b = cneg32(op_b, sb);

  assign accept = (state == IDLE) & start & ~Flush;
  assign stall  = ((state == IDLE) & start) | (state == MUL) | (state == DIV);
  // The divider's counter also paces the iterative multiplier.
  assign iter_step = ~Flush & ~iter_done &
                     ((state == MUL) | ((state == DIV) & ~dz_q & ~ovf_q));

  div_iter u_div (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .step      (iter_step),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .quotient  (quo),
    .remainder (rem),
    .iter_done (iter_done)
  );

`ifdef MULDIV_FAST_MUL_EN
  // prod_q[31:0] holds |b| from the accept edge.
  assign prod_raw = {32'd0, ma_q} * {32'd0, prod_q[31:0]};
  assign mul_last = 1'b1;
`else
  // Add-then-shift-right: high half accumulates, low half drains multiplier.
  logic [32:0] mul_sum;
  assign mul_sum  = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, ma_q} : 33'd0);
  assign prod_raw = prod_q;
  assign mul_last = iter_done;
`endif

  assign prod_fix = neg_q ? (~prod_raw + 64'd1) : prod_raw;
  assign mul_res  = (f3_q == F3_MUL) ? prod_fix[31:0] : prod_fix[63:32];
  assign is_rem   = (f3_q == F3_REM) | (f3_q == F3_REMU);
  assign div_res  = is_rem ? cneg32(rem, rneg_q) : cneg32(quo, neg_q);
  assign spec_res = dz_q ? (is_rem ? a_q : 32'hFFFF_FFFF)
                         : (is_rem ? 32'd0 : 32'h8000_0000);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      f3_q   <= '0;
      rd_q   <= '0;
      a_q    <= '0;
      ma_q   <= '0;
      prod_q <= '0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
      ovf_q  <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      rd_out <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state  <= funct3[2] ? DIV : MUL;
            f3_q   <= funct3;
            rd_q   <= rd_in;
            a_q    <= op_a;
            ma_q   <= mag_a;
            prod_q <= {32'd0, mag_b};
            neg_q  <= sa ^ sb;
            rneg_q <= sa;
            dz_q   <= funct3[2] & (op_b == 32'd0);
            ovf_q  <= funct3[2] & a_sgn & (op_a == 32'h8000_0000) &
                      (op_b == 32'hFFFF_FFFF);
          end
        end
        MUL: begin
          if (Flush) begin
            state <= IDLE;
          end else if (mul_last) begin
            state  <= DONE;
            done   <= 1'b1;
            result <= mul_res;
            rd_out <= rd_q;
          end else begin
`ifndef MULDIV_FAST_MUL_EN
            prod_q <= {mul_sum, prod_q[31:1]};
`endif
          end
        end
        DIV: begin
          if (Flush) begin
            state <= IDLE;
          end else if (dz_q | ovf_q) begin
            state  <= DONE;
            done   <= 1'b1;
            result <= spec_res;
            rd_out <= rd_q;
          end else if (iter_done) begin
            state  <= DONE;
            done   <= 1'b1;
            result <= div_res;
            rd_out <= rd_q;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: table-driven bench for ex_muldiv with a result scoreboard,
// plus hand-written sequences for flush, reset-abort and ignored starts.
module tb_ex_muldiv;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        Flush = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [4:0]  rd_in = '0;
  logic        stall, done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_muldiv dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .Flush  (Flush),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .rd_in  (rd_in),
    .stall  (stall),
    .done   (done),
    .result (result),
    .rd_out (rd_out)
  );

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
  } sb_t;

  sb_t         sb_q[$];
  vec_t        vecs[17];
  logic [31:0] last_res = '0;
  logic [4:0]  last_rd  = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issue one op, follow it to done, compare against the scoreboard.
  // poke_done raises start during the DONE cycle, which must be ignored.
  task automatic run_op(input vec_t v, input string nm, input bit poke_done);
    int  k;
    bit  seen;
    bit  stall_ok;
    sb_t e;
    @(negedge clk);
    funct3 = v.f3; op_a = v.a; op_b = v.b; rd_in = v.rd; start = 1'b1;
    #1 stall_ok = (stall === 1'b1);
    sb_q.push_back('{v.exp, v.rd});
    @(posedge clk); #1;
    // Scramble inputs so the DUT must have latched them.
    start = 1'b0; op_a = $urandom; op_b = $urandom; funct3 = 3'($urandom); rd_in = 5'($urandom);
    seen = 1'b0; k = 0;
    while (!seen && k < 100) begin
      @(posedge clk); #1; k++;
      if (done === 1'b1) seen = 1'b1;
      else if (stall !== 1'b1) stall_ok = 1'b0;
    end
    check({nm, " done_seen"}, 32'(seen), 32'd1);
    if (sb_q.size() > 0) e = sb_q.pop_front();
    else e = '{32'hDEAD_BEEF, 5'd0};
    if (seen) begin
      if (stall !== 1'b0) stall_ok = 1'b0;
      check({nm, " latency"}, 32'(k), 32'(v.lat));
      check({nm, " result"}, result, e.res);
      check({nm, " rd_out"}, 32'(rd_out), 32'(e.rd));
      check({nm, " stall"}, 32'(stall_ok), 32'd1);
      last_res = e.res;
      last_rd  = e.rd;
      if (poke_done) begin
        funct3 = 3'b101; op_a = 32'd9; op_b = 32'd2; start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      check({nm, " done_pulse"}, 32'(done), 32'd0);
      check({nm, " result_hold"}, result, e.res);
    end
  endtask

  // n cycles of expected quiet: no done, no stall, outputs unchanged.
  task automatic watch_idle(input string nm, input int n);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || stall !== 1'b0) bad++;
    end
    check({nm, " quiet_cycles"}, 32'(bad), 32'd0);
    check({nm, " result_kept"}, result, last_res);
    check({nm, " rd_kept"}, 32'(rd_out), 32'(last_rd));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{3'b000, 32'd7,          32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, MUL_LAT};
    vecs[1]  = '{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, MUL_LAT};
    vecs[2]  = '{3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  32'h0000_0000, MUL_LAT};
    vecs[3]  = '{3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFF, MUL_LAT};
    vecs[4]  = '{3'b000, 32'h1234_5678,  32'h10,        5'd5,  32'h2345_6780, MUL_LAT};
    vecs[5]  = '{3'b001, 32'h8000_0000,  32'h8000_0000, 5'd6,  32'h4000_0000, MUL_LAT};
    vecs[6]  = '{3'b100, 32'hFFFF_FFEC,  32'd3,         5'd7,  32'hFFFF_FFFA, 33};
    vecs[7]  = '{3'b110, 32'hFFFF_FFEC,  32'd3,         5'd8,  32'hFFFF_FFFE, 33};
    vecs[8]  = '{3'b101, 32'd100,        32'd7,         5'd9,  32'd14,        33};
    vecs[9]  = '{3'b111, 32'd100,        32'd7,         5'd10, 32'd2,         33};
    vecs[10] = '{3'b101, 32'd5,          32'd0,         5'd11, 32'hFFFF_FFFF, 1};
    vecs[11] = '{3'b110, 32'd5,          32'd0,         5'd12, 32'd5,         1};
    vecs[12] = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 1};
    vecs[13] = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 5'd14, 32'd0,         1};
    vecs[14] = '{3'b101, 32'hFFFF_FFFF,  32'd1,         5'd15, 32'hFFFF_FFFF, 33};
    vecs[15] = '{3'b110, 32'd7,          32'hFFFF_FFFE, 5'd16, 32'd1,         33};
    vecs[16] = '{3'b100, 32'd7,          32'hFFFF_FFFE, 5'd17, 32'hFFFF_FFFD, 33};

    // Reset state.
    #2 rst = 1'b0;
    #20;
    check("reset done",   32'(done),   32'd0);
    check("reset result", result,      32'd0);
    check("reset rd_out", 32'(rd_out), 32'd0);
    check("reset stall",  32'(stall),  32'd0);
    @(negedge clk) rst = 1'b1;

    for (int i = 0; i < 17; i++) run_op(vecs[i], $sformatf("vec%0d", i), 1'b0);

    // start during DONE must not launch a new op.
    run_op(vecs[0], "start_in_done", 1'b1);
    watch_idle("start_in_done", 40);

    // Flush together with start in IDLE: stays IDLE.
    @(negedge clk);
    funct3 = 3'b101; op_a = 32'd50; op_b = 32'd5; rd_in = 5'd20; start = 1'b1; Flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; Flush = 1'b0;
    watch_idle("flush_start_idle", 40);

    // Flush sampled at edge 10 of a DIV.
    @(negedge clk);
    funct3 = 3'b100; op_a = 32'd1000; op_b = 32'd3; rd_in = 5'd21; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 Flush = 1'b1;
    @(posedge clk); #1;
    Flush = 1'b0;
    check("flush_div stall", 32'(stall), 32'd0);
    check("flush_div done",  32'(done),  32'd0);
    watch_idle("flush_div", 40);
    run_op(vecs[8], "after_flush", 1'b0);

    // Reset asserted at edge 20 of a MUL.
    @(negedge clk);
    funct3 = 3'b011; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF; rd_in = 5'd22; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    @(posedge clk); #2 rst = 1'b0;
    #1;
    check("rst_mid result", result,      32'd0);
    check("rst_mid rd_out", 32'(rd_out), 32'd0);
    check("rst_mid done",   32'(done),   32'd0);
    check("rst_mid stall",  32'(stall),  32'd0);
    last_res = '0;
    last_rd  = '0;
    @(negedge clk) rst = 1'b1;
    watch_idle("rst_mid", 40);
    run_op(vecs[1], "after_rst", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
